// File: rtl/avl_st_2_avl_st_video_top.sv
// Unpacks a byte-packed 32-bit Avalon-ST stream into 24-bit RGB Avalon-ST Video, one pixel per beat.
// Define CTRL_PKT_EN to prefix each frame with a FRAME_WIDTH x FRAME_HEIGHT control packet.
module avl_st_2_avl_st_video_top #(
    parameter logic [15:0] FRAME_WIDTH  = 16'd800,
    parameter logic [15:0] FRAME_HEIGHT = 16'd480
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] in_avl_st_data,
    input  logic        in_avl_st_valid,
    input  logic        in_avl_st_startofpacket,
    input  logic        in_avl_st_endofpacket,
    output logic        in_avl_st_ready,
    output logic [23:0] out_avl_st_data,
    output logic        out_avl_st_valid,
    output logic        out_avl_st_startofpacket,
    output logic        out_avl_st_endofpacket,
    input  logic        out_avl_st_ready
);

`ifdef CTRL_PKT_EN
    typedef enum logic [2:0] {IDLE, CTRL_HDR, CTRL_DATA, VID_HDR, PIXELS} state_t;
`else
    typedef enum logic [1:0] {IDLE, VID_HDR, PIXELS} state_t;
`endif

    state_t      state, state_d;
    logic [63:0] byte_buf, byte_buf_d;
    logic [3:0]  cnt, cnt_d;
    logic        eop_seen, eop_seen_d;
    logic        in_rdy;
    logic        push, pop;

`ifdef CTRL_PKT_EN
    logic [1:0] beat, beat_d;

    // Each symbol carries one nibble of the frame dimensions in its low half.
    function automatic logic [23:0] ctrl_beat(input logic [1:0] b);
        case (b)
            2'd0:    ctrl_beat = {4'h0, FRAME_WIDTH[7:4],   4'h0, FRAME_WIDTH[11:8],  4'h0, FRAME_WIDTH[15:12]};
            2'd1:    ctrl_beat = {4'h0, FRAME_HEIGHT[11:8], 4'h0, FRAME_HEIGHT[15:12], 4'h0, FRAME_WIDTH[3:0]};
            default: ctrl_beat = {4'h0, 4'h3,               4'h0, FRAME_HEIGHT[3:0],  4'h0, FRAME_HEIGHT[7:4]};
        endcase
    endfunction
`endif

    always_comb begin
        state_d                  = state;
        in_rdy                   = 1'b0;
        out_avl_st_valid         = 1'b0;
        out_avl_st_data          = 24'h0;
        out_avl_st_startofpacket = 1'b0;
        out_avl_st_endofpacket   = 1'b0;
`ifdef CTRL_PKT_EN
        beat_d                   = beat;
`endif
        case (state)
            IDLE: begin
                // A sop word is left on the bus until the headers have gone out.
                in_rdy = !(in_avl_st_valid && in_avl_st_startofpacket);
                if (in_avl_st_valid && in_avl_st_startofpacket) begin
`ifdef CTRL_PKT_EN
                    state_d = CTRL_HDR;
`else
                    state_d = VID_HDR;
`endif
                end
            end
`ifdef CTRL_PKT_EN
            CTRL_HDR: begin
                out_avl_st_valid         = 1'b1;
                out_avl_st_data          = 24'h00000F;
                out_avl_st_startofpacket = 1'b1;
                if (out_avl_st_ready) begin
                    state_d = CTRL_DATA;
                    beat_d  = 2'd0;
                end
            end
            CTRL_DATA: begin
                out_avl_st_valid       = 1'b1;
                out_avl_st_data        = ctrl_beat(beat);
                out_avl_st_endofpacket = (beat == 2'd2);
                if (out_avl_st_ready) begin
                    beat_d = beat + 2'd1;
                    if (beat == 2'd2) state_d = VID_HDR;
                end
            end
`endif
            VID_HDR: begin
                out_avl_st_valid         = 1'b1;
                out_avl_st_startofpacket = 1'b1;
                if (out_avl_st_ready) state_d = PIXELS;
            end
            PIXELS: begin
                in_rdy                 = (cnt <= 4'd4) && !eop_seen;
                out_avl_st_valid       = (cnt >= 4'd3);
                out_avl_st_data        = {byte_buf[7:0], byte_buf[15:8], byte_buf[23:16]};
                out_avl_st_endofpacket = eop_seen && (cnt < 4'd6);
                if (out_avl_st_valid && out_avl_st_ready && out_avl_st_endofpacket) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_avl_st_ready = in_rdy & rst_n;

    assign push = (state == PIXELS) && in_avl_st_valid && in_rdy;
    assign pop  = (state == PIXELS) && out_avl_st_valid && out_avl_st_ready;

    // Pop drops the oldest three bytes; a push lands just above whatever remains.
    always_comb begin
        byte_buf_d = byte_buf;
        cnt_d      = cnt;
        eop_seen_d = eop_seen;
        if (pop && out_avl_st_endofpacket) begin
            byte_buf_d = 64'h0;
            cnt_d      = 4'd0;
            eop_seen_d = 1'b0;
        end else begin
            if (pop) begin
                byte_buf_d = byte_buf_d >> 24;
                cnt_d      = cnt_d - 4'd3;
            end
            if (push) begin
                byte_buf_d = byte_buf_d | ({32'h0, in_avl_st_data} << {cnt_d, 3'b000});
                cnt_d      = cnt_d + 4'd4;
                eop_seen_d = eop_seen | in_avl_st_endofpacket;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            byte_buf <= 64'h0;
            cnt      <= 4'd0;
            eop_seen <= 1'b0;
        end else begin
            state    <= state_d;
            byte_buf <= byte_buf_d;
            cnt      <= cnt_d;
            eop_seen <= eop_seen_d;
        end
    end

`ifdef CTRL_PKT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) beat <= 2'd0;
        else        beat <= beat_d;
    end
`endif

endmodule
